// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path:
// FSM state encoding, opcodes, mux-select and ALU encodings, ALUOp type
// and the immediate-format decode used by both cores.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN (see multicycle_controller).
package riscv_ctrl_pkg;

  // FSM states; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  // Opcodes, Instr[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the FSM asks of the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Immediate format from opcode; R-type and unknown opcodes fall back to I
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_for = IMM_S;
      OP_BRANCH: imm_src_for = IMM_B;
      OP_JAL:    imm_src_for = IMM_J;
      default:   imm_src_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: ALUOp + funct3/op[5]/funct7b5 -> ALUControl.
// Purely combinational so the single-cycle core can reuse it unchanged.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Funct decode; sub only for R-type with funct7b5 (addi ignores bit 30)
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences PC/IR/regfile/memory enables and
// datapath mux selects, stalling on MemReady.
// Optional macro MULTICYCLE_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in a
// sticky ILLEGAL state and raise IllegalInstr; otherwise they execute as a NOP.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);

  state_t  state_reg;
  state_t  state_next;
  alu_op_t alu_op;
  logic    pc_update;
  logic    branch;
  logic    ir_write;
  logic    reg_write;
  logic    mem_write;
  logic    instr_done;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= RESET_STATE;
    else        state_reg <= state_next;
  end

  // Next-state and Moore outputs; FETCH/MEMWRITE also look at MemReady
  always_comb begin
    state_next = state_reg;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state_reg)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_update  = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_JAL:            state_next = JAL;
          OP_BRANCH:         state_next = BEQ;
          default:           state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // Strobe held until the memory acknowledges
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (MemReady) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end
      end
      EXECUTER: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      JAL: begin
        // PC <- target in ALUOut while ALU forms OldPC+4 for the link
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      ILLEGAL: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        state_next = ILLEGAL;
`else
        instr_done = 1'b1;
        state_next = FETCH;
`endif
      end
      default: state_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign ImmSrc = imm_src_for(op);

  // Enables are masked while reset is low so no strobe escapes during reset
  assign PCWrite   = reset & (pc_update | (branch & Zero));
  assign IRWrite   = reset & ir_write;
  assign RegWrite  = reset & reg_write;
  assign MemWrite  = reset & mem_write;
  assign InstrDone = reset & instr_done;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign IllegalInstr = (state_reg == ILLEGAL);
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath: one instruction takes 3–5 states.
- Sequences PC, IR, register file, memory and ALU mux selects from opcode, funct3, funct7b5 and Zero.
- Stalls on a memory-ready handshake.
- Sits beside the datapath in the core top level and replaces the single-cycle combinational decoder.

Parameters:
- RESET_STATE, FETCH: state entered on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current access.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J; combinational from op.
- RegWrite  out  1  register file write enable.
- InstrDone  out  1  one-cycle pulse on the last state of each instruction.

Behaviour:
- Moore FSM. Outputs decode from the state register only, except:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ImmSrc and the ALUControl funct decode are combinational.
- Reset low: state ← FETCH immediately. PCWrite, IRWrite, RegWrite, MemWrite and InstrDone are forced 0. Mux selects show FETCH values.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when MemReady=1. Hold in FETCH while MemReady=0; else → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Dispatch on op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR.
  - 0110011 (R-type) → EXECUTER.
  - 0010011 (I-ALU) → EXECUTEI.
  - 1101111 (jal) → JAL.
  - 1100011 (beq) → BEQ.
  - anything else → ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while MemReady=0; else → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays asserted and the state holds until MemReady=1. Then InstrDone=1 → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1 → FETCH.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 by funct3: 000 → sub if (op[5] & funct7b5), else add; 010 → slt; 110 → or; 111 → and; other → add.
- Latencies with MemReady tied 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
- Any unused state encoding → FETCH on the next edge.
- Reset asserted mid-instruction aborts it; no write strobe is emitted afterwards.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL is a sticky state with all enables 0.
  - Extra output IllegalInstr=1 while in ILLEGAL.
  - Exit only via reset.
- Undefined:
  - ILLEGAL asserts no enables and InstrDone=1, then → FETCH (executes as a NOP).
  - No IllegalInstr port.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (4-bit);
  - opcode localparams;
  - ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl encodings;
  - the ALUOp type.
- Sub-module alu_decoder (ALUOp, funct3, op[5], funct7b5 → ALUControl), reusable by the single-cycle core.

Test Plan:
- Reset low for 3 cycles with MemReady=1 → all enables 0; release reset → IRWrite=1, PCWrite=1 in cycle 1; state DECODE in cycle 2.
- op=0000011, MemReady=0 for 2 cycles in MEMREAD → state holds; RegWrite=1 with ResultSrc=01 exactly once; InstrDone after 7 cycles total.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER; RegWrite in ALUWB; 4-cycle instruction.
- op=1100011 with Zero=1 → PCWrite=1 in BEQ. Same with Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- op=0100011, MemReady dropped for 1 cycle in MEMWRITE → MemWrite held for 2 cycles; RegWrite never asserted.
- op=1111111 → with MULTICYCLE_ILLEGAL_TRAP_EN, IllegalInstr=1 held until reset. Without it, InstrDone pulse, then FETCH.
